// File: rtl/vga_layer_ctrl.sv
// -----------------------------------------------------------------------------
// vga_layer_ctrl
//
// Parametrised VGA display controller: pixel-tick divider, horizontal/vertical
// timing generator, N-layer priority compositor with page selection and a
// registered RGB output. The blanking/sync flags are delayed to line up with
// the generator latency, so rgb, video_on, hsync and vsync all change together.
//
// Optional build macro:
//   VGA_LAYER_BORDER_EN - when defined, the outermost visible row/column is
//                         forced to red (12'hF00, MSB-aligned to RGB_W) over
//                         all layers, for monitor alignment.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   page_sel     in   requested display page (taken at frame boundary only)
//   layer_page   in   page tag of layer i at [i*PAGE_W +: PAGE_W]
//   layer_global in   layer i shown on every page
//   layer_on     in   per-layer pixel-hit flags from the generators
//   layer_rgb    in   per-layer colour at [i*RGB_W +: RGB_W]
//   pixel_x/y    out  current horizontal/vertical counters
//   p_tick       out  one-clk pixel-tick strobe
//   frame_start  out  pulse on the tick where the counters wrap to (0,0)
//   page_cur     out  page currently displayed
//   video_on     out  visible-area flag aligned with rgb
//   hsync/vsync  out  sync outputs aligned with rgb
//   rgb          out  registered pixel colour
// -----------------------------------------------------------------------------
module vga_layer_ctrl #(
  parameter int               H_DISPLAY = 640,
  parameter int               H_FP      = 16,
  parameter int               H_SYNC    = 96,
  parameter int               H_BP      = 48,
  parameter int               V_DISPLAY = 480,
  parameter int               V_FP      = 10,
  parameter int               V_SYNC    = 2,
  parameter int               V_BP      = 33,
  parameter int               CLK_DIV   = 2,
  parameter logic             SYNC_POL  = 1'b0,
  parameter int               N_LAYERS  = 19,
  parameter int               PAGE_W    = 4,
  parameter int               RGB_W     = 12,
  parameter int               GEN_LAT   = 1,
  parameter logic [RGB_W-1:0] BG_RGB    = {RGB_W{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PAGE_W-1:0]          page_sel,
  input  logic [N_LAYERS*PAGE_W-1:0] layer_page,
  input  logic [N_LAYERS-1:0]        layer_global,
  input  logic [N_LAYERS-1:0]        layer_on,
  input  logic [N_LAYERS*RGB_W-1:0]  layer_rgb,
  output logic [11:0]                pixel_x,
  output logic [11:0]                pixel_y,
  output logic                       p_tick,
  output logic                       frame_start,
  output logic [PAGE_W-1:0]          page_cur,
  output logic                       video_on,
  output logic                       hsync,
  output logic                       vsync,
  output logic [RGB_W-1:0]           rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_DISPLAY);
  localparam logic [11:0] V_VIS    = 12'(V_DISPLAY);
  localparam logic [11:0] HS_START = 12'(H_DISPLAY + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_START = 12'(V_DISPLAY + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_DISPLAY + V_FP + V_SYNC - 1);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Pixel-tick divider. The strobe is masked while reset is held so the tick
  // is low in the reset cycle even when CLK_DIV = 1.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             tick;

  always_comb begin
    div_next = div_reg + 1'b1;
    if (div_reg == DIV_LAST) begin
      div_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_next;
    end
  end

  assign tick = (div_reg == DIV_LAST) && !reset;

  // ---------------------------------------------------------------------------
  // Horizontal / vertical counters and frame-boundary page latch
  // ---------------------------------------------------------------------------
  logic [11:0]       h_reg;
  logic [11:0]       v_reg;
  logic [PAGE_W-1:0] page_cur_reg;
  logic              frame_end;

  assign frame_end = tick && (h_reg == H_LAST) && (v_reg == V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (tick) begin
      if (h_reg == H_LAST) begin
        h_reg <= '0;
        v_reg <= (v_reg == V_LAST) ? 12'd0 : v_reg + 12'd1;
      end else begin
        h_reg <= h_reg + 12'd1;
      end
    end
  end

  // The page only changes between frames; page_sel is ignored at all other
  // times so a frame never shows two pages.
  always_ff @(posedge clk) begin
    if (reset) begin
      page_cur_reg <= '0;
    end else if (frame_end) begin
      page_cur_reg <= page_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Raw timing flags derived from the counters
  // ---------------------------------------------------------------------------
  logic video_raw;
  logic hsync_raw;
  logic vsync_raw;

  assign video_raw = (h_reg < H_VIS) && (v_reg < V_VIS);
  assign hsync_raw = ((h_reg >= HS_START) && (h_reg <= HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vsync_raw = ((v_reg >= VS_START) && (v_reg <= VS_END)) ? SYNC_POL : ~SYNC_POL;

`ifdef VGA_LAYER_BORDER_EN
  localparam int PIPE_W = 4;
  localparam logic [11:0] H_EDGE = 12'(H_DISPLAY - 1);
  localparam logic [11:0] V_EDGE = 12'(V_DISPLAY - 1);
  // 12'hF00 left-aligned in a wide word, then the top RGB_W bits are kept.
  localparam logic [RGB_W+11:0] BORDER_WIDE = {12'hF00, {RGB_W{1'b0}}};
  localparam logic [RGB_W-1:0]  BORDER_RGB  = BORDER_WIDE[RGB_W+11 -: RGB_W];

  logic border_raw;
  assign border_raw = video_raw &&
                      ((h_reg == 12'd0) || (h_reg == H_EDGE) ||
                       (v_reg == 12'd0) || (v_reg == V_EDGE));
`else
  localparam int PIPE_W = 3;
`endif

  // Bit layout of the delay line: {[border,] vsync, hsync, video}
  localparam logic [PIPE_W-1:0] PIPE_IDLE = PIPE_W'({~SYNC_POL, ~SYNC_POL, 1'b0});

  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;

`ifdef VGA_LAYER_BORDER_EN
  assign pipe_in = {border_raw, vsync_raw, hsync_raw, video_raw};
`else
  assign pipe_in = {vsync_raw, hsync_raw, video_raw};
`endif

  // ---------------------------------------------------------------------------
  // Delay line matching the generator latency (GEN_LAT ticks)
  // ---------------------------------------------------------------------------
  generate
    if (GEN_LAT > 0) begin : g_pipe
      logic [PIPE_W-1:0] stage_reg [GEN_LAT];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < GEN_LAT; i++) begin
            stage_reg[i] <= PIPE_IDLE;
          end
        end else if (tick) begin
          stage_reg[0] <= pipe_in;
          for (int i = 1; i < GEN_LAT; i++) begin
            stage_reg[i] <= stage_reg[i-1];
          end
        end
      end

      assign pipe_out = stage_reg[GEN_LAT-1];
    end else begin : g_no_pipe
      assign pipe_out = pipe_in;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Priority compositor: lowest-index eligible layer wins
  // ---------------------------------------------------------------------------
  logic [N_LAYERS-1:0] eligible;
  logic [RGB_W-1:0]    layer_colour;
  logic [RGB_W-1:0]    pixel_colour;

  genvar gi;
  generate
    for (gi = 0; gi < N_LAYERS; gi++) begin : g_elig
      assign eligible[gi] = layer_on[gi] &&
                            (layer_global[gi] ||
                             (layer_page[gi*PAGE_W +: PAGE_W] == page_cur_reg));
    end
  endgenerate

  // Scanning from the highest index down lets lower indices overwrite.
  always_comb begin
    layer_colour = BG_RGB;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        layer_colour = layer_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  always_comb begin
    pixel_colour = layer_colour;
    if (!pipe_out[0]) begin
      pixel_colour = '0;
    end
`ifdef VGA_LAYER_BORDER_EN
    else if (pipe_out[3]) begin
      pixel_colour = BORDER_RGB;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output register: all four display outputs update on the same tick
  // ---------------------------------------------------------------------------
  logic [RGB_W-1:0] rgb_reg;
  logic             video_reg;
  logic             hsync_reg;
  logic             vsync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_reg   <= '0;
      video_reg <= 1'b0;
      hsync_reg <= ~SYNC_POL;
      vsync_reg <= ~SYNC_POL;
    end else if (tick) begin
      rgb_reg   <= pixel_colour;
      video_reg <= pipe_out[0];
      hsync_reg <= pipe_out[1];
      vsync_reg <= pipe_out[2];
    end
  end

  assign pixel_x     = h_reg;
  assign pixel_y     = v_reg;
  assign p_tick      = tick;
  assign frame_start = frame_end;
  assign page_cur    = page_cur_reg;
  assign video_on    = video_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign rgb         = rgb_reg;

endmodule

// File: tb/tb_vga_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_layer_ctrl
//
// Scoreboard bench for vga_layer_ctrl with a reduced timing (24 x 13 ticks per
// frame). A driver process randomises the layer inputs on every pixel tick and
// pushes the expected registered output into a queue; a monitor process pops
// and compares on the following tick. Expected values come from tick-index
// arithmetic (position = tick number modulo line/frame length) and a plain
// first-match search over the layers.
// -----------------------------------------------------------------------------
module tb_vga_layer_ctrl;

  localparam int HD = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VD = 8,  VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HD + HFP + HSW + HBP;   // 24
  localparam int VT = VD + VFP + VSW + VBP;   // 13
  localparam int FT = HT * VT;                // ticks per frame
  localparam int CDIV = 2;
  localparam bit SP   = 1'b0;
  localparam int NL   = 10;
  localparam int PW   = 4;
  localparam int RW   = 12;
  localparam int GL   = 2;
  localparam int RUN_TICKS = 10 * FT;
  localparam int CLK_BUDGET = RUN_TICKS * CDIV + 4000;

  logic              clk = 1'b0;
  logic              reset;
  logic [PW-1:0]     page_sel;
  logic [NL*PW-1:0]  layer_page;
  logic [NL-1:0]     layer_global;
  logic [NL-1:0]     layer_on;
  logic [NL*RW-1:0]  layer_rgb;
  logic [11:0]       pixel_x;
  logic [11:0]       pixel_y;
  logic              p_tick;
  logic              frame_start;
  logic [PW-1:0]     page_cur;
  logic              video_on;
  logic              hsync;
  logic              vsync;
  logic [RW-1:0]     rgb;

  always #5 clk = ~clk;

  vga_layer_ctrl #(
    .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .CLK_DIV(CDIV), .SYNC_POL(SP), .N_LAYERS(NL), .PAGE_W(PW),
    .RGB_W(RW), .GEN_LAT(GL), .BG_RGB({RW{1'b1}})
  ) dut (
    .clk(clk), .reset(reset), .page_sel(page_sel), .layer_page(layer_page),
    .layer_global(layer_global), .layer_on(layer_on), .layer_rgb(layer_rgb),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .p_tick(p_tick),
    .frame_start(frame_start), .page_cur(page_cur), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  typedef struct packed {
    logic [RW-1:0] rgb;
    logic          vid;
    logic          hs;
    logic          vs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   in_reset = 1'b1;
  bit   done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Colour chosen by the layer stack for the given page, ignoring blanking.
  function automatic logic [RW-1:0] model_colour(input int page);
    for (int i = 0; i < NL; i++) begin
      if (layer_on[i] && (layer_global[i] || (int'(layer_page[i*PW +: PW]) == page)))
        return layer_rgb[i*RW +: RW];
    end
    return {RW{1'b1}};
  endfunction

  // Monitor: every tick the output register shows the previous tick's result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!in_reset && p_tick && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rgb",      32'(rgb),      32'(e.rgb));
        check("video_on", 32'(video_on), 32'(e.vid));
        check("hsync",    32'(hsync),    32'(e.hs));
        check("vsync",    32'(vsync),    32'(e.vs));
      end
    end
  end

  // Driver / model state
  int n;            // ticks since the last reset
  int total_ticks;
  int page_model;
  int clk_cnt;
  int clocks;
  bit mid_done;

  task automatic apply_reset(input string why);
    reset    = 1'b1;
    in_reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("rst_pixel_x",     32'(pixel_x),     32'd0);
    check("rst_pixel_y",     32'(pixel_y),     32'd0);
    check("rst_rgb",         32'(rgb),         32'd0);
    check("rst_hsync",       32'(hsync),       32'(!SP));
    check("rst_vsync",       32'(vsync),       32'(!SP));
    check("rst_video_on",    32'(video_on),    32'd0);
    check("rst_page_cur",    32'(page_cur),    32'd0);
    check("rst_p_tick",      32'(p_tick),      32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    n          = 0;
    page_model = 0;
    clk_cnt    = 0;
    in_reset   = 1'b0;
    $display("reset (%s) released at %0t", why, $time);
  endtask

  task automatic randomise_layers();
    int mode;
    mode = $urandom_range(0, 4);
    for (int i = 0; i < NL; i++) begin
      layer_on[i]            = ($urandom_range(0, 3) == 0);
      layer_global[i]        = ($urandom_range(0, 3) == 0);
      layer_page[i*PW +: PW] = PW'($urandom_range(0, 3));
      layer_rgb[i*RW +: RW]  = RW'($urandom);
    end
    if (mode == 3) begin
      // Two global layers: index 4 must beat index 9, or 9 alone.
      layer_on                = '0;
      layer_on[9]             = 1'b1;
      layer_on[4]             = ($urandom_range(0, 1) == 1);
      layer_global[4]         = 1'b1;
      layer_global[9]         = 1'b1;
      layer_rgb[4*RW +: RW]   = 12'h0F0;
      layer_rgb[9*RW +: RW]   = 12'h00F;
    end else if (mode == 4) begin
      layer_on = '0;
    end
  endtask

  initial begin
    exp_t e;
    int m, hm, vm;
    reset        = 1'b1;
    page_sel     = '0;
    layer_page   = '0;
    layer_global = '0;
    layer_on     = '0;
    layer_rgb    = '0;
    n = 0; total_ticks = 0; page_model = 0; clk_cnt = 0; clocks = 0; mid_done = 1'b0;
    repeat (3) @(negedge clk);
    apply_reset("power-on");

    while (total_ticks < RUN_TICKS && clocks < CLK_BUDGET) begin
      @(negedge clk);
      clocks++;
      clk_cnt++;
      if (!p_tick) begin
        if (!mid_done && total_ticks > 4 * FT && pixel_x == 12'd10 && pixel_y == 12'd5) begin
          mid_done = 1'b1;
          apply_reset("mid-frame");
        end
      end else begin
        // Position/state of the DUT during tick n
        check("pixel_x",     32'(pixel_x),     32'(n % HT));
        check("pixel_y",     32'(pixel_y),     32'((n / HT) % VT));
        check("page_cur",    32'(page_cur),    32'(page_model));
        check("frame_start", 32'(frame_start), 32'((n % FT) == FT - 1));
        if (n > 0) check("tick_period", 32'(clk_cnt), 32'(CDIV));
        clk_cnt = 0;

        randomise_layers();

        // Flags at the output after this tick belong to counter tick n-GL.
        m = n - GL;
        if (m < 0) begin
          e.vid = 1'b0; e.hs = !SP; e.vs = !SP; hm = -1; vm = -1;
        end else begin
          hm = m % HT;
          vm = (m / HT) % VT;
          e.vid = (hm < HD) && (vm < VD);
          e.hs  = (hm >= HD + HFP && hm < HD + HFP + HSW) ? SP : !SP;
          e.vs  = (vm >= VD + VFP && vm < VD + VFP + VSW) ? SP : !SP;
        end
        e.rgb = e.vid ? model_colour(page_model) : '0;
`ifdef VGA_LAYER_BORDER_EN
        if (e.vid && (hm == 0 || hm == HD - 1 || vm == 0 || vm == VD - 1))
          e.rgb = 12'hF00;
`endif
        exp_q.push_back(e);

        if ($urandom_range(0, 49) == 0) page_sel = PW'($urandom_range(0, 3));
        if ((n % FT) == FT - 1) begin
          page_model = int'(page_sel);
          $display("frame %0d complete, next page %0d", total_ticks / FT, page_model);
        end
        n++;
        total_ticks++;
      end
    end
    check("run_completed_within_budget", 32'(total_ticks >= RUN_TICKS), 32'd1);

    // Let the monitor consume the final expectation.
    for (int k = 0; k < 4 * CDIV && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    done = 1'b1;
    $finish;
  end

endmodule

// File: doc/vga_layer_ctrl.md
Name: vga_layer_ctrl

Overview:
- Parametrised VGA display controller: timing generator, pixel-tick divider, N-layer priority compositor with page selection, registered RGB output.
- Successor to the fixed 640x480, 19-layer, 4-bit-switch display top.
- New capabilities: configurable timing, per-layer page tags, frame-synchronous page switching, programmable generator latency with sync alignment.
- Sits between the LM32 Wishbone VGA register file (page_sel) and the graphics/text generators (layer_on/layer_rgb).

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_DISPLAY, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- SYNC_POL, 0, active level of hsync/vsync
- N_LAYERS, 19, number of layers; layer 0 has highest priority
- PAGE_W, 4, page number width
- RGB_W, 12, colour width
- GEN_LAT, 1, generator latency in pixel ticks from pixel_x/y to layer_on/layer_rgb (0..4)
- BG_RGB, all ones, colour when no layer wins

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- page_sel, in, PAGE_W, requested display page
- layer_page, in, N_LAYERS*PAGE_W, page tag of layer i at bits [i*PAGE_W +: PAGE_W]
- layer_global, in, N_LAYERS, 1 = layer visible on every page
- layer_on, in, N_LAYERS, layer pixel-hit flags from generators
- layer_rgb, in, N_LAYERS*RGB_W, per-layer colour
- pixel_x, out, 12, current horizontal count
- pixel_y, out, 12, current vertical count
- p_tick, out, 1, one-clk pixel-tick strobe
- frame_start, out, 1, one-clk pulse on the tick where counters wrap to (0,0)
- page_cur, out, PAGE_W, page currently displayed
- video_on, out, 1, delayed visible-area flag, aligned with rgb
- hsync, out, 1, delayed hsync, aligned with rgb
- vsync, out, 1, delayed vsync, aligned with rgb
- rgb, out, RGB_W, registered pixel colour

Behaviour:
- Reset values: all counters, divider, pixel_x, pixel_y, p_tick, frame_start, page_cur, video_on and rgb = 0; hsync/vsync = ~SYNC_POL. Reset mid-frame restarts at (0,0) on the next clk.
- Divider: counts 0..CLK_DIV-1; p_tick=1 when count == CLK_DIV-1. CLK_DIV=1 gives p_tick constant 1 after reset.
- Counters advance only on p_tick.
  - h wraps at H_TOTAL-1 = H_DISPLAY+H_FP+H_SYNC+H_BP-1.
  - v increments on h wrap and wraps at V_TOTAL-1.
  - Defaults: H_TOTAL 800, V_TOTAL 525.
- Raw sync: hsync active while h in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1]; vsync likewise on v.
- Raw video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
- Page latch: page_sel is sampled into page_cur only on the p_tick where h = H_TOTAL-1 and v = V_TOTAL-1. frame_start pulses in the same clk. Changes to page_sel at any other time must not alter the current frame.
- Compositor, evaluated combinationally on the generator outputs:
  - Layer i eligible = layer_on[i] && (layer_global[i] || layer_page[i] == page_cur).
  - Lowest-index eligible layer wins; colour = its layer_rgb slice.
  - No eligible layer: colour = BG_RGB.
  - Delayed video_on = 0: colour = 0.
- Alignment: raw video_on, hsync and vsync pass through a GEN_LAT-stage shift register advanced on p_tick. rgb, video_on, hsync and vsync then register together on p_tick. Total latency from counter value to output = GEN_LAT+1 ticks, identical for all four outputs.
- page_cur update is not delayed by GEN_LAT. The first GEN_LAT ticks of a new frame fall in the blanking interval, so no visible pixel mixes pages (requires GEN_LAT <= H_BP).
- Outputs hold their values between ticks.

Optional Feature:
- Macro VGA_LAYER_BORDER_EN.
- Defined: the visible pixels with h==0, h==H_DISPLAY-1, v==0 or v==V_DISPLAY-1 output colour 12'hF00 (scaled to RGB_W, MSB-aligned). This overrides all layers, for monitor alignment.
- Undefined: no border logic; normal compositing on edges.

Test Plan:
- Defaults, reset released: hsync falls at tick h=656+2 (GEN_LAT+1) and rises at 752+2. vsync is low for exactly 2 lines. p_tick period is 2 clk. Frame length is 420000 ticks.
- page_sel 0->3 at line 200: page_cur stays 0 until frame_start, then 3. A layer tagged page 3 with layer_on=1 appears only from the next frame.
- layer_on[4] and layer_on[9] both 1, both eligible, rgb 0x0F0 and 0x00F: output 0x0F0. Clear bit 4: output 0x00F.
- No eligible layer in visible area: rgb=0xFFF. In blanking: rgb=0x000 regardless of layer_on.
- Assert reset at h=300, v=100 for one clk: next clk pixel_x=0, pixel_y=0, rgb=0, hsync=vsync=1. Counting restarts cleanly.
- GEN_LAT=3, CLK_DIV=1: a generator pixel-hit on x=10 appears on rgb exactly 4 ticks after pixel_x=10, coincident with video_on=1.
